led_blink_ctrl: RTL
===================

# led_blink_ctrl

Command-driven scheduler for the board's 8 LEDs. It takes 16-bit commands from the remote command decoder over a valid/ready handshake and gives each LED its own mode and blink half-period. A shared tick prescaler paces all blinking LEDs. The block replaces fixed-rate LED blinking with run-time programmable per-LED control.

## Interface
- CLK_FREQ, 25_000_000, clk frequency in Hz
- TICK_HZ, 100, blink time base; tick period = CLK_FREQ/TICK_HZ cycles (integer, ≥2)
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low; clock is clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_data  in  16  [15:13] opcode, [12:10] LED index, [9:8] unused, [7:0] argument
- cmd_done  out  1  one-cycle pulse when a command finishes
- cmd_err  out  1  one-cycle pulse with cmd_done when the opcode is invalid
- leds  out  8  LED drive, 1 = on

## Operation
- Per-LED state: mode (OFF, ON, BLINK), half[7:0], phase[7:0].
- Opcodes:
  - 0 NOP: no state change.
  - 1 SET_PERIOD: if arg≠0, mode=BLINK, half=arg, phase=0, led=1. If arg=0, mode=OFF, led=0.
  - 2 FORCE_ON: mode=ON, led=1.
  - 3 FORCE_OFF: mode=OFF, led=0.
  - 4 SYNC: every BLINK LED gets phase=0 and led=1; prescaler cleared; index ignored.
  - 5 ALL_OFF: every LED gets mode=OFF and led=0; half values are kept.
  - 6, 7: invalid. No state change; cmd_err pulses.
- Prescaler counts 0..CLK_FREQ/TICK_HZ−1, then wraps. Internal tick is high for the one cycle the count sits at terminal.
- On each tick, for every LED in BLINK mode:
  - if phase ≥ half−1: phase=0 and led toggles;
  - otherwise phase+1.
- OFF and ON LEDs ignore ticks and hold their value.
- Command FSM:
  - IDLE: cmd_ready=1. If cmd_valid=1, latch cmd_data and go to EXEC.
  - EXEC: cmd_ready=0. Apply the command, go to DONE.
  - DONE: cmd_ready=0. cmd_done=1, plus cmd_err=1 if invalid. Go to IDLE.
- Simultaneous tick and command apply in EXEC:
  - For the addressed LED, or all LEDs for SYNC/ALL_OFF, the command wins and that tick's update is dropped.
  - Unaffected LEDs take the tick normally.
  - A SYNC in the same cycle as a tick clears the prescaler; the tick still applies to no LED.
- cmd_data is sampled only at the accepting edge. Later changes do not affect an executing command.
- Reset values: leds=0, all modes OFF, half=0, phase=0, prescaler=0, FSM=IDLE, cmd_ready=1, cmd_done=0, cmd_err=0.
- rst_n asserted mid-command aborts it. No cmd_done is produced for the aborted command.

## Timing
- Accept edge E0 is the edge where cmd_valid & cmd_ready.
- State changes from the command are applied at edge E1 and appear on leds after E1.
- cmd_done and cmd_err are high for exactly the cycle between E1 and E2.
- cmd_ready is low from E0 to E2. The next command can be accepted at E3, so throughput is one command per 3 cycles.
- First toggle after SET_PERIOD(h) lands on the h-th tick after E1. Blink period is 2·h ticks.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Width rules:
  - phase compare is unsigned 8-bit;
  - half=1 toggles on every tick;
  - half=255 gives a 510-tick period;
  - the prescaler width is sized to fit CLK_FREQ/TICK_HZ−1.

## Test plan
All scenarios use CLK_FREQ=1000 and TICK_HZ=100, so one tick every 10 cycles.
- Reset then idle 200 cycles: leds=8'h00, cmd_ready=1, no cmd_done.
- SET_PERIOD LED2 arg=3: leds[2]=1 after E1, then toggles every 30 cycles; other LEDs stay 0. cmd_done pulses exactly once, 1 cycle wide.
- FORCE_ON LED7, then ALL_OFF: leds=8'h80 after the first command and 8'h00 after the second. Re-issuing SET_PERIOD LED7 arg=0 keeps leds[7]=0.
- Opcode 6 on LED1: cmd_done and cmd_err both pulse in the same cycle; leds unchanged.
- Back-to-back commands with cmd_valid held high: accepted every 3 cycles; cmd_ready low for 2 cycles after each accept.
- Blink LED0 (arg=1) and LED1 (arg=2), issue SYNC timed so EXEC coincides with a tick:
  - both LEDs go to 1 with phase 0;
  - the next tick arrives exactly 10 cycles later;
  - rst_n pulsed low mid-blink forces leds=0 immediately.

Source files
------------

// File: rtl/led_blink_ctrl.sv
// Command-driven per-LED scheduler: each of 8 LEDs is OFF, ON or blinking with its own
// half-period, paced by one shared tick prescaler. Commands arrive over valid/ready.
module led_blink_ctrl #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [7:0]  leds
);

    localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
    localparam int PW = $clog2(TICK_CYC);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);

    localparam logic [2:0] OP_SET     = 3'd1;
    localparam logic [2:0] OP_ON      = 3'd2;
    localparam logic [2:0] OP_OFF     = 3'd3;
    localparam logic [2:0] OP_SYNC    = 3'd4;
    localparam logic [2:0] OP_ALL_OFF = 3'd5;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2} mode_t;

    state_t        state_r, state_s;
    logic [13:0]   cmd_r;
    logic          ready_r, done_r, err_r;
    logic [PW-1:0] cnt_r;
    logic          tick_s, exec_s;
    logic [2:0]    op_s, idx_s;
    logic [7:0]    arg_s;
    logic [7:0]    own_s;
    mode_t         mode_r  [8];
    mode_t         mode_s  [8];
    logic [7:0]    half_r  [8];
    logic [7:0]    half_s  [8];
    logic [7:0]    phase_r [8];
    logic [7:0]    phase_s [8];
    logic [7:0]    led_r, led_s;

    // Unused bits [9:8] are dropped when the command is latched.
    assign op_s   = cmd_r[13:11];
    assign idx_s  = cmd_r[10:8];
    assign arg_s  = cmd_r[7:0];
    assign exec_s = (state_r == ST_EXEC);
    assign tick_s = (cnt_r == TICK_LAST);

    assign cmd_ready = ready_r;
    assign cmd_done  = done_r;
    assign cmd_err   = err_r;
    assign leds      = led_r;

    // Command FSM next-state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Command FSM state, latched command and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cmd_r   <= 14'd0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE && cmd_valid) begin
                cmd_r <= {cmd_data[15:10], cmd_data[7:0]};
            end
            ready_r <= (state_s == ST_IDLE);
            done_r  <= exec_s;
            err_r   <= exec_s && (op_s == 3'd6 || op_s == 3'd7);
        end
    end

    // Shared prescaler; SYNC restarts the blink time base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if ((exec_s && op_s == OP_SYNC) || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + PW'(1);
        end
    end

    // LEDs touched by the executing command; those skip this cycle's tick.
    always_comb begin
        own_s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (exec_s && (op_s == OP_SYNC || op_s == OP_ALL_OFF)) begin
                own_s[i] = 1'b1;
            end else if (exec_s && idx_s == 3'(i) &&
                         (op_s == OP_SET || op_s == OP_ON || op_s == OP_OFF)) begin
                own_s[i] = 1'b1;
            end else begin
                own_s[i] = 1'b0;
            end
        end
    end

    // Per-LED next state: command application, otherwise tick-driven blinking.
    always_comb begin
        led_s = led_r;
        for (int i = 0; i < 8; i++) begin
            mode_s[i]  = mode_r[i];
            half_s[i]  = half_r[i];
            phase_s[i] = phase_r[i];
        end
        for (int i = 0; i < 8; i++) begin
            if (own_s[i]) begin
                case (op_s)
                    OP_SET: begin
                        if (arg_s != 8'd0) begin
                            mode_s[i]  = MODE_BLINK;
                            half_s[i]  = arg_s;
                            phase_s[i] = 8'd0;
                            led_s[i]   = 1'b1;
                        end else begin
                            mode_s[i] = MODE_OFF;
                            led_s[i]  = 1'b0;
                        end
                    end
                    OP_ON: begin
                        mode_s[i] = MODE_ON;
                        led_s[i]  = 1'b1;
                    end
                    OP_OFF, OP_ALL_OFF: begin
                        mode_s[i] = MODE_OFF;
                        led_s[i]  = 1'b0;
                    end
                    OP_SYNC: begin
                        if (mode_r[i] == MODE_BLINK) begin
                            phase_s[i] = 8'd0;
                            led_s[i]   = 1'b1;
                        end else begin
                            led_s[i] = led_r[i];
                        end
                    end
                    default: led_s[i] = led_r[i];
                endcase
            end else if (tick_s && mode_r[i] == MODE_BLINK) begin
                if (phase_r[i] >= half_r[i] - 8'd1) begin
                    phase_s[i] = 8'd0;
                    led_s[i]   = ~led_r[i];
                end else begin
                    phase_s[i] = phase_r[i] + 8'd1;
                end
            end else begin
                led_s[i] = led_r[i];
            end
        end
    end

    // Per-LED state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                mode_r[i]  <= MODE_OFF;
                half_r[i]  <= 8'd0;
                phase_r[i] <= 8'd0;
            end
        end else begin
            led_r <= led_s;
            for (int i = 0; i < 8; i++) begin
                mode_r[i]  <= mode_s[i];
                half_r[i]  <= half_s[i];
                phase_r[i] <= phase_s[i];
            end
        end
    end

endmodule
